// File: rtl/regfile_pkg.sv
// Shared register-file types for the writeback path: address/data widths and
// the queued write entry.
package regfile_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_queue_if.sv
// Writeback queue bus: ALU/load result inputs, register-file write port,
// decode-stage hazard/forward query and status.
interface reg_writeback_queue_if
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
);
    logic                          aluValid;
    logic [REG_ADDR_W-1:0]         aluDest;
    logic [REG_DATA_W-1:0]         aluData;
    logic                          memValid;
    logic [REG_ADDR_W-1:0]         memDest;
    logic [REG_DATA_W-1:0]         memData;
    logic                          inReady;
    logic                          regWrite;
    logic [REG_ADDR_W-1:0]         writeReg;
    logic [REG_DATA_W-1:0]         writeData;
    logic [REG_ADDR_W-1:0]         queryReg1;
    logic [REG_ADDR_W-1:0]         queryReg2;
    logic                          hazard1;
    logic                          hazard2;
    logic                          fwdValid1;
    logic                          fwdValid2;
    logic [REG_DATA_W-1:0]         fwdData1;
    logic [REG_DATA_W-1:0]         fwdData2;
    logic [$clog2(DEPTH+1)-1:0]    count;
    logic                          overflow;

    modport master (
        output aluValid, aluDest, aluData, memValid, memDest, memData,
               queryReg1, queryReg2,
        input  inReady, regWrite, writeReg, writeData, hazard1, hazard2,
               fwdValid1, fwdValid2, fwdData1, fwdData2, count, overflow
    );

    modport slave (
        input  aluValid, aluDest, aluData, memValid, memDest, memData,
               queryReg1, queryReg2,
        output inReady, regWrite, writeReg, writeData, hazard1, hazard2,
               fwdValid1, fwdValid2, fwdData1, fwdData2, count, overflow
    );

endinterface

// File: rtl/wb_fifo.sv
// In-order circular buffer of writeback entries: up to two pushes and one pop
// per cycle, with every slot exposed oldest-first for hazard comparison.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic [1:0]                   push_cnt_i,
    input  wb_entry_t                    push0_i,
    input  wb_entry_t                    push1_i,
    input  logic                         pop_i,
    output wb_entry_t                    head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output wb_entry_t                    age_o [DEPTH],
    output logic [DEPTH-1:0]             age_valid_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        count_d  = count_q + CNT_W'(push_cnt_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_cnt_i != 2'd0) mem_q[wr_ptr_q] <= push0_i;
        if (push_cnt_i == 2'd2) mem_q[wr_ptr_q + PTR_W'(1)] <= push1_i;
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_o[k]       = mem_q[rd_ptr_q + PTR_W'(k)];
            age_valid_o[k] = CNT_W'(k) < count_q;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/reg_writeback_queue.sv
// Writeback queue top: input ordering, register-file output stage, hazard and
// forward compare, sticky overflow. Forwarding is built only with WB_FORWARD_EN.
module reg_writeback_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 resetN,
    reg_writeback_queue_if.slave wb
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t              alu_entry, mem_entry, push0, push1, head;
    wb_entry_t              age [DEPTH];
    logic [DEPTH-1:0]       age_valid;
    logic [CNT_W-1:0]       count;
    logic                   in_ready, pop;
    logic [1:0]             push_cnt;
    logic                   reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0]  write_reg_q, write_reg_d;
    logic [REG_DATA_W-1:0]  write_data_q, write_data_d;
    logic                   overflow_q, overflow_d;
    logic [REG_ADDR_W-1:0]  query [2];
    logic [1:0]             hazard;

    assign alu_entry = {wb.aluDest, wb.aluData};
    assign mem_entry = {wb.memDest, wb.memData};

    // Two free slots are required so both sources can always land together.
    assign in_ready = count <= CNT_W'(DEPTH - 2);
    assign push_cnt = in_ready ? ({1'b0, wb.aluValid} + {1'b0, wb.memValid}) : 2'd0;
    assign push0    = wb.aluValid ? alu_entry : mem_entry;
    assign push1    = mem_entry;
    assign pop      = count != '0;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock       (clock),
        .resetN      (resetN),
        .push_cnt_i  (push_cnt),
        .push0_i     (push0),
        .push1_i     (push1),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .age_o       (age),
        .age_valid_o (age_valid)
    );

    always_comb begin
        reg_write_d  = pop;
        write_reg_d  = pop ? head.dest : write_reg_q;
        write_data_d = pop ? head.data : write_data_q;
        overflow_d   = overflow_q | (!in_ready & (wb.aluValid | wb.memValid));
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            overflow_q   <= overflow_d;
        end
    end

    assign query[0] = wb.queryReg1;
    assign query[1] = wb.queryReg2;

`ifdef WB_FORWARD_EN
    logic [REG_DATA_W-1:0] fwd_data [2];

    // Output stage is the oldest pending write; later queue matches override it.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            hazard[n]   = reg_write_q && (write_reg_q == query[n]);
            fwd_data[n] = hazard[n] ? write_data_q : '0;
            for (int k = 0; k < DEPTH; k++) begin
                if (age_valid[k] && (age[k].dest == query[n])) begin
                    hazard[n]   = 1'b1;
                    fwd_data[n] = age[k].data;
                end
            end
        end
    end

    assign wb.fwdValid1 = hazard[0];
    assign wb.fwdValid2 = hazard[1];
    assign wb.fwdData1  = fwd_data[0];
    assign wb.fwdData2  = fwd_data[1];
`else
    logic unused_age_data;

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            hazard[n] = reg_write_q && (write_reg_q == query[n]);
            for (int k = 0; k < DEPTH; k++) begin
                if (age_valid[k] && (age[k].dest == query[n])) hazard[n] = 1'b1;
            end
        end
    end

    always_comb begin
        unused_age_data = 1'b0;
        for (int k = 0; k < DEPTH; k++) unused_age_data = unused_age_data ^ (^age[k].data);
    end

    assign wb.fwdValid1 = 1'b0;
    assign wb.fwdValid2 = 1'b0;
    assign wb.fwdData1  = '0;
    assign wb.fwdData2  = '0;
`endif

    assign wb.hazard1   = hazard[0];
    assign wb.hazard2   = hazard[1];
    assign wb.inReady   = in_ready;
    assign wb.regWrite  = reg_write_q;
    assign wb.writeReg  = write_reg_q;
    assign wb.writeData = write_data_q;
    assign wb.count     = count;
    assign wb.overflow  = overflow_q;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Randomized bench for reg_writeback_queue against a queue-based model, with
// directed scenarios pinning the model to hand-computed values.
module tb_reg_writeback_queue;
    import regfile_pkg::*;

    localparam int DEPTH = 4;

    logic clock  = 1'b0;
    logic resetN = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   chk_en = 1'b0;

    reg_writeback_queue_if #(.DEPTH(DEPTH)) wbi ();

    reg_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clock  (clock),
        .resetN (resetN),
        .wb     (wbi)
    );

    always #5 clock = ~clock;

    // Behavioural model: pending writes in arrival order plus the output stage.
    wb_entry_t  mq[$];
    bit         m_rw  = 1'b0;
    logic [2:0] m_wr  = '0;
    logic [7:0] m_wd  = '0;
    bit         m_ovf = 1'b0;
    int         m_n;
    wb_entry_t  m_e;

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            mq.delete();
            m_rw  = 1'b0;
            m_wr  = '0;
            m_wd  = '0;
            m_ovf = 1'b0;
        end else begin
            m_n = mq.size();
            if (m_n > 0) begin
                m_e  = mq.pop_front();
                m_rw = 1'b1;
                m_wr = m_e.dest;
                m_wd = m_e.data;
            end else begin
                m_rw = 1'b0;
            end
            if ((DEPTH - m_n) >= 2) begin
                if (wbi.aluValid) mq.push_back({wbi.aluDest, wbi.aluData});
                if (wbi.memValid) mq.push_back({wbi.memDest, wbi.memData});
            end else if (wbi.aluValid || wbi.memValid) begin
                m_ovf = 1'b1;
            end
        end
    end

    function automatic void mdl_query(input logic [2:0] q, output bit hz, output logic [7:0] fd);
        hz = 1'b0;
        fd = '0;
        if (m_rw && m_wr == q) begin
            hz = 1'b1;
            fd = m_wd;
        end
        foreach (mq[i]) begin
            if (mq[i].dest == q) begin
                hz = 1'b1;
                fd = mq[i].data;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: DUT outputs against the model every cycle.
    bit         e_hz1, e_hz2;
    logic [7:0] e_fd1, e_fd2;

    always @(negedge clock) begin
        if (chk_en) begin
            mdl_query(wbi.queryReg1, e_hz1, e_fd1);
            mdl_query(wbi.queryReg2, e_hz2, e_fd2);
`ifndef WB_FORWARD_EN
            e_fd1 = '0;
            e_fd2 = '0;
`endif
            chk("count",     32'(wbi.count),     32'(mq.size()));
            chk("inReady",   32'(wbi.inReady),   32'((DEPTH - mq.size()) >= 2));
            chk("regWrite",  32'(wbi.regWrite),  32'(m_rw));
            chk("writeReg",  32'(wbi.writeReg),  32'(m_wr));
            chk("writeData", 32'(wbi.writeData), 32'(m_wd));
            chk("overflow",  32'(wbi.overflow),  32'(m_ovf));
            chk("hazard1",   32'(wbi.hazard1),   32'(e_hz1));
            chk("hazard2",   32'(wbi.hazard2),   32'(e_hz2));
`ifdef WB_FORWARD_EN
            chk("fwdValid1", 32'(wbi.fwdValid1), 32'(e_hz1));
            chk("fwdValid2", 32'(wbi.fwdValid2), 32'(e_hz2));
`else
            chk("fwdValid1", 32'(wbi.fwdValid1), 32'(0));
            chk("fwdValid2", 32'(wbi.fwdValid2), 32'(0));
`endif
            chk("fwdData1",  32'(wbi.fwdData1),  32'(e_fd1));
            chk("fwdData2",  32'(wbi.fwdData2),  32'(e_fd2));
        end
    end

    task automatic set_in(input bit av, input logic [2:0] ad, input logic [7:0] adat,
                          input bit mv, input logic [2:0] md, input logic [7:0] mdat);
        wbi.aluValid = av;
        wbi.aluDest  = ad;
        wbi.aluData  = adat;
        wbi.memValid = mv;
        wbi.memDest  = md;
        wbi.memData  = mdat;
    endtask

    task automatic set_idle();
        set_in(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    endtask

    localparam logic [7:0] FWD20 =
`ifdef WB_FORWARD_EN
        8'h20;
`else
        8'h00;
`endif

    initial begin
        set_idle();
        wbi.queryReg1 = 3'd0;
        wbi.queryReg2 = 3'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #2 resetN = 1'b1;
        chk_en = 1'b1;

        // Reset state
        @(negedge clock);
        chk("rst_count",    32'(wbi.count),     32'd0);
        chk("rst_regWrite", 32'(wbi.regWrite),  32'd0);
        chk("rst_wdata",    32'(wbi.writeData), 32'd0);
        chk("rst_overflow", 32'(wbi.overflow),  32'd0);
        chk("rst_inReady",  32'(wbi.inReady),   32'd1);

        // Single ALU write, two-edge latency
        #2 set_in(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00);
        @(negedge clock);
        chk("lat_count1", 32'(wbi.count), 32'd1);
        chk("lat_rw_e0",  32'(wbi.regWrite), 32'd0);
        #2 set_idle();
        @(negedge clock);
        chk("lat_rw_e1",  32'(wbi.regWrite), 32'd1);
        chk("lat_wreg",   32'(wbi.writeReg), 32'd3);
        chk("lat_wdata",  32'(wbi.writeData), 32'h5A);
        @(negedge clock);
        chk("lat_rw_e2",  32'(wbi.regWrite), 32'd0);

        // ALU and load same cycle: ALU drains first
        #2 set_in(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22);
        @(negedge clock);
        chk("dual_count2", 32'(wbi.count), 32'd2);
        #2 set_idle();
        @(negedge clock);
        chk("dual_wreg1",  32'(wbi.writeReg), 32'd1);
        chk("dual_wdat1",  32'(wbi.writeData), 32'h11);
        chk("dual_count1", 32'(wbi.count), 32'd1);
        @(negedge clock);
        chk("dual_wreg2",  32'(wbi.writeReg), 32'd2);
        chk("dual_wdat2",  32'(wbi.writeData), 32'h22);
        chk("dual_count0", 32'(wbi.count), 32'd0);
        @(negedge clock);

        // Same destination twice: hazard until the younger write leaves
        #2 set_in(1'b1, 3'd5, 8'h10, 1'b1, 3'd5, 8'h20);
        wbi.queryReg1 = 3'd5;
        wbi.queryReg2 = 3'd6;
        @(negedge clock);
        chk("dup_hz_e0",  32'(wbi.hazard1), 32'd1);
        chk("dup_fwd_e0", 32'(wbi.fwdData1), 32'(FWD20));
        chk("q6_hazard2", 32'(wbi.hazard2), 32'd0);
        chk("q6_fwdv2",   32'(wbi.fwdValid2), 32'd0);
        #2 set_idle();
        @(negedge clock);
        chk("dup_wdat1",  32'(wbi.writeData), 32'h10);
        chk("dup_hz_e1",  32'(wbi.hazard1), 32'd1);
        chk("dup_fwd_e1", 32'(wbi.fwdData1), 32'(FWD20));
        @(negedge clock);
        chk("dup_wdat2",  32'(wbi.writeData), 32'h20);
        chk("dup_hz_e2",  32'(wbi.hazard1), 32'd1);
        @(negedge clock);
        chk("dup_hz_e3",  32'(wbi.hazard1), 32'd0);

        // Saturation: both sources every cycle until one is dropped
        #2 set_in(1'b1, 3'd0, 8'hA0, 1'b1, 3'd1, 8'hA1);
        @(negedge clock);
        chk("sat_count2", 32'(wbi.count), 32'd2);
        #2 set_in(1'b1, 3'd2, 8'hA2, 1'b1, 3'd3, 8'hA3);
        @(negedge clock);
        chk("sat_count3", 32'(wbi.count), 32'd3);
        chk("sat_ready0", 32'(wbi.inReady), 32'd0);
        chk("sat_ovf0",   32'(wbi.overflow), 32'd0);
        #2 set_in(1'b1, 3'd4, 8'hA4, 1'b1, 3'd5, 8'hA5);
        @(negedge clock);
        chk("sat_ovf1",   32'(wbi.overflow), 32'd1);
        chk("sat_cnt_e2", 32'(wbi.count), 32'd2);
        #2 set_idle();
        repeat (6) @(negedge clock);
        chk("sat_ovf_sticky", 32'(wbi.overflow), 32'd1);
        chk("sat_drained",    32'(wbi.count), 32'd0);

        // Reset with three queued and a write in flight
        #2 set_in(1'b1, 3'd1, 8'hB1, 1'b1, 3'd2, 8'hB2);
        @(negedge clock);
        #2 set_in(1'b1, 3'd3, 8'hB3, 1'b1, 3'd4, 8'hB4);
        @(negedge clock);
        chk("mid_count3", 32'(wbi.count), 32'd3);
        chk("mid_rw1",    32'(wbi.regWrite), 32'd1);
        #2 set_idle();
        resetN = 1'b0;
        #1;
        chk("mid_rw0",    32'(wbi.regWrite), 32'd0);
        chk("mid_count0", 32'(wbi.count), 32'd0);
        chk("mid_ovf0",   32'(wbi.overflow), 32'd0);
        @(negedge clock);
        #2 resetN = 1'b1;
        repeat (4) @(negedge clock);
        chk("post_rst_rw", 32'(wbi.regWrite), 32'd0);

        // Randomized traffic with idle gaps so the queue also drains
        for (int i = 0; i < 400; i++) begin
            #2;
            if ((i % 40) >= 32) set_idle();
            else set_in(($urandom % 4) != 0, 3'($urandom), 8'($urandom),
                        ($urandom % 2) != 0, 3'($urandom), 8'($urandom));
            wbi.queryReg1 = 3'($urandom);
            wbi.queryReg2 = 3'($urandom);
            @(negedge clock);
        end
        #2 set_idle();
        repeat (8) @(negedge clock);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

Writeback-side initiator for the 8-entry, 8-bit register file: collects results from the ALU and the data-memory load path, buffers them in a small in-order queue, and drives the register file's write port (regWrite / write address / writeData) at most one write per cycle. It also reports pending-write hazards so the decode stage can stall reads of registers whose new value has not yet reached the register file.

## Interface
- DEPTH, 4, queue entries; power of two, ≥ 2
- DATA_W, 8, data width
- ADDR_W, 3, register address width
- clock  in  1  rising-edge clock
- resetN  in  1  asynchronous, active-low reset
- aluValid  in  1  ALU result present this cycle
- aluDest  in  ADDR_W  ALU destination register
- aluData  in  DATA_W  ALU result
- memValid  in  1  load result present this cycle
- memDest  in  ADDR_W  load destination register
- memData  in  DATA_W  load data
- inReady  out  1  at least two free slots (both sources may enqueue this cycle)
- regWrite  out  1  write strobe to register file
- writeReg  out  ADDR_W  register-file write address
- writeData  out  DATA_W  register-file write data
- queryReg1, queryReg2  in  ADDR_W  decode-stage source registers
- hazard1, hazard2  out  1  pending write to queryRegN
- fwdValid1, fwdValid2  out  1  forward data available (see Configuration)
- fwdData1, fwdData2  out  DATA_W  youngest pending value for queryRegN
- count  out  $clog2(DEPTH+1)  occupied queue entries
- overflow  out  1  sticky: a valid input was dropped

## Operation
- Enqueue: aluValid then memValid, same cycle, in that order (ALU entry older). Accepted only when inReady = 1 at that edge; otherwise the input is dropped and overflow sets (sticky until reset).
- inReady = (DEPTH − count) ≥ 2, combinational from count.
- Drain: each edge with count > 0 pops the head into the output stage: regWrite ← 1, writeReg/writeData ← head. Edge with count = 0: regWrite ← 0, writeReg/writeData hold.
- Push and pop in the same edge: count += pushes − 1; pop of an entry pushed that same edge is impossible (pushed entries are visible at the head from the next edge).
- Pointers wrap modulo DEPTH; count never exceeds DEPTH.
- hazardN = 1 when any occupied entry's dest == queryRegN, or regWrite = 1 and writeReg == queryRegN. Combinational.
- Same destination queued twice: both writes issue, in order; the last one wins in the register file.
- No special treatment of register 0.

## Timing
- Reset (async assert, sync release): count 0, pointers 0, regWrite 0, writeReg 0, writeData 0, overflow 0, fwdValidN 0, fwdDataN 0; queue contents don't-care.
- Latency, empty queue: input at edge E → regWrite = 1 during the cycle after edge E+1.
- Throughput: one write per cycle; sustained two-per-cycle input fills the queue and deasserts inReady.
- Reset mid-operation discards all queued and in-flight writes; regWrite drops immediately.
- hazard/fwd outputs reflect state after the most recent edge; zero-cycle path from queryRegN.

## Configuration
- WB_FORWARD_EN defined: fwdValidN = hazardN; fwdDataN = data of the youngest matching entry (output stage counts as oldest).
- Undefined: fwdValidN and fwdDataN tied 0; the decode stage must stall on hazardN.

## Structure
- Shared package regfile_pkg: REG_ADDR_W = 3, REG_DATA_W = 8, typedef struct packed wb_entry_t {dest, data}.
- One sub-module: wb_fifo (circular buffer of wb_entry_t, dual push port, single pop, exposes all entries for hazard compare).
- Top: input ordering, output stage, hazard/forward compare, overflow flag.

## Test plan
- Reset, then aluValid with dest 3, data 0x5A at edge 0 → regWrite = 1, writeReg 3, writeData 0x5A after edge 1, regWrite 0 after edge 2.
- aluValid (dest 1, 0x11) and memValid (dest 2, 0x22) same cycle → writes to 1 then 2 on consecutive cycles; count 2 → 1 → 0.
- DEPTH = 4, both sources valid every cycle → inReady falls when count ≥ 3; forced extra valid → overflow = 1 and stays 1; no lost accepted writes.
- Queue dest 5 (0x10) then dest 5 (0x20), queryReg1 = 5 → hazard1 = 1 until the second write leaves the output stage; with WB_FORWARD_EN fwdData1 = 0x20.
- queryReg2 = 6 with no pending writes to 6 → hazard2 = 0, fwdValid2 = 0.
- resetN low with 3 entries queued and regWrite = 1 → regWrite 0 immediately, count 0; no writes after release.
